ped_crossing_ctrl: RTL



---
 rtl/ped_crossing_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian WALK / DON'T-WALK stage driven by a one-hot RED/YELLOW/GREEN light.
// Define PED_COUNTDOWN_EN to expose the live phase timer on countdown; otherwise countdown reads 0.
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 4,
    parameter int FLASH_DIV    = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             fault
);

    localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        CLEAR,
        FAULT
    } state_t;

    state_t             state;
    logic               btn_meta;
    logic               btn_sync;
    logic               btn_prev;
    logic [2:0]         light_q;
    logic [CNT_W-1:0]   timer;
    logic [FLASH_W-1:0] flash_cnt;

    logic btn_rise;
    logic light_red;
    logic red_rise;
    logic light_illegal;

    // The button is asynchronous; the light comes from the same clock domain and is used directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
            light_q  <= 3'b000;
        end else begin
            btn_meta <= ped_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            light_q  <= light;
        end
    end

    assign btn_rise      = btn_sync & ~btn_prev;
    assign light_red     = (light == 3'b100);
    assign red_rise      = light_red && (light_q != 3'b100);
    assign light_illegal = (light[2] & light[1]) | (light[2] & light[0]) | (light[1] & light[0]);

    // Priority inside one edge: illegal light, then leaving RED (abort), then timer expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            timer       <= '0;
            flash_cnt   <= '0;
            req_pending <= 1'b0;
            fault       <= 1'b0;
        end else begin
            req_pending <= req_pending | btn_rise;
            if (light_illegal) begin
                state     <= FAULT;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                timer     <= '0;
                flash_cnt <= '0;
                fault     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_pending && red_rise) begin
                            state       <= WALK;
                            walk        <= 1'b1;
                            dont_walk   <= 1'b0;
                            timer       <= CNT_W'(WALK_CYCLES - 1);
                            req_pending <= 1'b0;
                        end
                    end
                    WALK: begin
                        if (!light_red) begin
                            state     <= IDLE;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            timer     <= '0;
                        end else if (timer == '0) begin
                            state     <= CLEAR;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            timer     <= CNT_W'(CLEAR_CYCLES - 1);
                            flash_cnt <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    CLEAR: begin
                        if (!light_red || timer == '0) begin
                            state     <= IDLE;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            timer     <= '0;
                            flash_cnt <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                            if (flash_cnt == FLASH_W'(FLASH_DIV - 1)) begin
                                flash_cnt <= '0;
                                dont_walk <= ~dont_walk;
                            end else begin
                                flash_cnt <= flash_cnt + 1'b1;
                            end
                        end
                    end
                    FAULT: begin
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        timer     <= '0;
                        fault     <= 1'b1;
                    end
                    default: begin
                        state     <= IDLE;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        timer     <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PED_COUNTDOWN_EN
    assign countdown = timer;
`else
    assign countdown = '0;
`endif

endmodule
